// File: rtl/wbuf_axi_wr_master_if.sv
// -----------------------------------------------------------------------------
// wbuf_axi_wr_master_if
// AXI4 write-channel bundle (AW, W, B) between the write-buffer drain master
// and an AXI slave. Signal names carry the direction as seen from the master.
//
// Modports:
//   master : drives AW/W payload + valids and bready; samples readies, B.
//   slave  : the mirror image.
// Parameter:
//   ID_W   : width of awid_o / bid_i.
// -----------------------------------------------------------------------------
interface wbuf_axi_wr_master_if #(
  parameter int ID_W = 4
) ();

  // AW channel
  logic [ID_W-1:0] awid_o;
  logic [31:0]     awaddr_o;
  logic [7:0]      awlen_o;
  logic [2:0]      awsize_o;
  logic [1:0]      awburst_o;
  logic            awvalid_o;
  logic            awready_i;

  // W channel
  logic [31:0]     wdata_o;
  logic [3:0]      wstrb_o;
  logic            wlast_o;
  logic            wvalid_o;
  logic            wready_i;

  // B channel
  logic [ID_W-1:0] bid_i;
  logic [1:0]      bresp_i;
  logic            bvalid_i;
  logic            bready_o;

  modport master (
    output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    input  awready_i,
    output wdata_o, wstrb_o, wlast_o, wvalid_o,
    input  wready_i,
    input  bid_i, bresp_i, bvalid_i,
    output bready_o
  );

  modport slave (
    input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    output awready_i,
    input  wdata_o, wstrb_o, wlast_o, wvalid_o,
    output wready_i,
    output bid_i, bresp_i, bvalid_i,
    input  bready_o
  );

endinterface

// File: rtl/wbuf_axi_wr_master.sv
// -----------------------------------------------------------------------------
// wbuf_axi_wr_master
// Drains the single 128-bit dirty line offered by the data-cache write buffer
// as one 4-beat INCR burst of 32-bit words on AXI4, then returns a one-cycle
// completion strobe (wb_done_o) on the B handshake.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   wb_wen_i      : buffer holds a valid line (level, held until done)
//   wb_waddr_i    : line address, bits [3:0] ignored
//   wb_wdata_i    : line data, word k = bits [32k+31:32k]
//   wb_done_o     : burst complete strobe (B handshake cycle only)
//   busy_o        : a burst is in flight
//   bus_err_o     : sticky non-OKAY B response flag (optional, see below)
//   axi           : AW/W/B channels (wbuf_axi_wr_master_if.master)
//
// Optional feature: define WBUF_AXI_BRESP_CHECK_EN to add bus_err_o, which is
// set on any B handshake with bresp_i != OKAY and held until reset. Without
// the macro bresp_i is ignored.
// -----------------------------------------------------------------------------
module wbuf_axi_wr_master #(
  parameter int            ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_wen_i,
  input  logic [31:0]   wb_waddr_i,
  input  logic [127:0]  wb_wdata_i,
  output logic          wb_done_o,
  output logic          busy_o,
`ifdef WBUF_AXI_BRESP_CHECK_EN
  output logic          bus_err_o,
`endif
  wbuf_axi_wr_master_if.master axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    beat_reg, beat_next;
  logic [27:0]   addr_reg;
  logic [127:0]  line_reg;
  logic          latch_en;
  logic          awvalid_c, wvalid_c, bready_c, done_c;

  // Line split into beat-sized words so the W mux indexes by beat number.
  logic [31:0]   word [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign word[gi] = line_reg[32*gi +: 32];
    end
  endgenerate

  // State and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  // Request capture: once latched, the buffer's inputs no longer affect
  // the burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= 28'd0;
      line_reg <= 128'd0;
    end else if (latch_en) begin
      addr_reg <= wb_waddr_i[31:4];
      line_reg <= wb_wdata_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    latch_en   = 1'b0;
    awvalid_c  = 1'b0;
    wvalid_c   = 1'b0;
    bready_c   = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_wen_i) begin
          latch_en   = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        awvalid_c = 1'b1;
        if (axi.awready_i) begin
          state_next = DATA;
          beat_next  = 2'd0;
        end
      end
      DATA: begin
        wvalid_c = 1'b1;
        if (axi.wready_i) begin
          // 2-bit counter wraps to 0 on the last beat.
          beat_next = beat_reg + 2'd1;
          if (beat_reg == 2'd3) begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        bready_c = 1'b1;
        if (axi.bvalid_i) begin
          // Response code never changes the flow; no retry.
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign axi.awid_o    = AXI_ID;
  assign axi.awaddr_o  = {addr_reg, 4'b0000};
  assign axi.awlen_o   = 8'd3;
  assign axi.awsize_o  = 3'b010;
  assign axi.awburst_o = 2'b01;
  assign axi.awvalid_o = awvalid_c;

  assign axi.wdata_o   = word[beat_reg];
  assign axi.wstrb_o   = 4'hF;
  assign axi.wlast_o   = (state_reg == DATA) && (beat_reg == 2'd3);
  assign axi.wvalid_o  = wvalid_c;

  assign axi.bready_o  = bready_c;

  assign wb_done_o     = done_c;
  assign busy_o        = (state_reg != IDLE);

`ifdef WBUF_AXI_BRESP_CHECK_EN
  logic bus_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_reg <= 1'b0;
    end else if (done_c && (axi.bresp_i != 2'b00)) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign bus_err_o = bus_err_reg;

  // BID and the ignored low address bits are intentionally unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, axi.bid_i, wb_waddr_i[3:0]};
`else
  // BID, BRESP and the ignored low address bits are intentionally unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, axi.bid_i, axi.bresp_i, wb_waddr_i[3:0]};
`endif

endmodule

// File: tb/tb_wbuf_axi_wr_master.sv
// -----------------------------------------------------------------------------
// tb_wbuf_axi_wr_master
// Drives write-buffer requests into wbuf_axi_wr_master, plays a randomly
// stalling AXI slave, and compares every burst against the expected
// transaction derived from the request (aligned address, four words in
// order, a single done strobe, fixed latencies).
// -----------------------------------------------------------------------------
module tb_wbuf_axi_wr_master;

  localparam int ID_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_wen;
  logic [31:0]   wb_waddr;
  logic [127:0]  wb_wdata;
  logic          wb_done;
  logic          busy;
`ifdef WBUF_AXI_BRESP_CHECK_EN
  logic          bus_err;
`endif

  wbuf_axi_wr_master_if #(.ID_W(ID_W)) axi ();

  wbuf_axi_wr_master #(.ID_W(ID_W), .AXI_ID(4'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wen_i   (wb_wen),
    .wb_waddr_i (wb_waddr),
    .wb_wdata_i (wb_wdata),
    .wb_done_o  (wb_done),
    .busy_o     (busy),
`ifdef WBUF_AXI_BRESP_CHECK_EN
    .bus_err_o  (bus_err),
`endif
    .axi        (axi.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs
  int         aw_pct = 100, w_pct = 100, b_pct = 100;
  int         aw_hold = 0, w_hold = 0, w_hold_beat = -1;
  logic [1:0] bresp_val = 2'b00;

  // Observed transaction
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic        wl_q[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          first_aw_cyc = -1;
  int          done_cyc = 0;
  bit          aw_acc = 0;
  bit          aw_stall = 0, w_stall = 0;
  logic [31:0] stall_awaddr, stall_wdata;
  logic        stall_wlast;

  task automatic clear_mon();
    aw_q.delete();
    wd_q.delete();
    wl_q.delete();
    done_cnt     = 0;
    first_aw_cyc = -1;
  endtask

  // One clock cycle: slave decides readies at the falling edge, outputs are
  // sampled 1 ns later and handshakes are recorded.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (axi.awvalid_o && aw_hold > 0) begin
      axi.awready_i = 1'b0;
      aw_hold--;
    end else begin
      axi.awready_i = ($urandom_range(99) < aw_pct);
    end
    if (axi.wvalid_o && wd_q.size() == w_hold_beat && w_hold > 0) begin
      axi.wready_i = 1'b0;
      w_hold--;
    end else begin
      axi.wready_i = ($urandom_range(99) < w_pct);
    end
    axi.bvalid_i = ($urandom_range(99) < b_pct);
    axi.bresp_i  = bresp_val;
    axi.bid_i    = ID_W'($urandom);
    #1;
    if (aw_stall) begin
      check_val("aw_stall_valid", axi.awvalid_o, 1'b1);
      check_val("aw_stall_addr", axi.awaddr_o, stall_awaddr);
    end
    if (w_stall) begin
      check_val("w_stall_valid", axi.wvalid_o, 1'b1);
      check_val("w_stall_data", axi.wdata_o, stall_wdata);
      check_val("w_stall_last", axi.wlast_o, stall_wlast);
    end
    if (axi.wvalid_o && !aw_acc) check_val("w_before_aw", axi.wvalid_o, 1'b0);
    aw_stall     = axi.awvalid_o && !axi.awready_i;
    stall_awaddr = axi.awaddr_o;
    w_stall      = axi.wvalid_o && !axi.wready_i;
    stall_wdata  = axi.wdata_o;
    stall_wlast  = axi.wlast_o;
    if (axi.awvalid_o && first_aw_cyc < 0) first_aw_cyc = cyc;
    if (axi.awvalid_o && axi.awready_i) begin
      aw_q.push_back(axi.awaddr_o);
      check_val("awid", axi.awid_o, 4'd1);
      check_val("awlen", axi.awlen_o, 8'd3);
      check_val("awsize", axi.awsize_o, 3'd2);
      check_val("awburst", axi.awburst_o, 2'd1);
      aw_acc = 1;
    end
    if (axi.wvalid_o && axi.wready_i) begin
      wd_q.push_back(axi.wdata_o);
      wl_q.push_back(axi.wlast_o);
      check_val("wstrb", axi.wstrb_o, 4'hF);
    end
    if (wb_done) begin
      check_val("done_without_b", axi.bvalid_i && axi.bready_o, 1'b1);
      done_cnt++;
      done_cyc = cyc;
      aw_acc   = 0;
    end
  endtask

  // Runs one burst. fresh=1: request driven now from IDLE. fresh=0: the
  // request was left pending at the previous done (back-to-back case).
  task automatic run_burst(input string name, input logic [31:0] addr, input logic [127:0] data,
                           input bit fresh, input bit keep, input logic [31:0] naddr,
                           input logic [127:0] ndata, input bit zero_wait);
    int  req_cyc;
    int  prev_done;
    bit  scrambled;
    clear_mon();
    req_cyc   = cyc;
    prev_done = done_cyc;
    scrambled = 0;
    if (fresh) begin
      wb_wen   = 1'b1;
      wb_waddr = addr;
      wb_wdata = data;
    end
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      tick();
      if (first_aw_cyc >= 0 && !scrambled && done_cnt == 0) begin
        wb_waddr  = $urandom;
        wb_wdata  = {4{32'hFFFF_FFFF}};
        scrambled = 1;
      end
    end
    check_val({name, "_done_seen"}, done_cnt > 0, 1'b1);
    if (keep) begin
      wb_wen   = 1'b1;
      wb_waddr = naddr;
      wb_wdata = ndata;
    end else begin
      wb_wen = 1'b0;
    end
    check_val({name, "_aw_count"}, aw_q.size(), 1);
    if (aw_q.size() > 0) check_val({name, "_awaddr"}, aw_q[0], {addr[31:4], 4'b0000});
    check_val({name, "_w_count"}, wd_q.size(), 4);
    for (int k = 0; k < 4 && k < wd_q.size(); k++) begin
      check_val($sformatf("%s_beat%0d", name, k), wd_q[k], data[32*k +: 32]);
      check_val($sformatf("%s_last%0d", name, k), wl_q[k], k == 3);
    end
    if (fresh) check_val({name, "_aw_latency"}, first_aw_cyc - req_cyc, 1);
    else       check_val({name, "_aw_gap_after_done"}, first_aw_cyc - prev_done, 2);
    if (zero_wait) check_val({name, "_done_latency"}, done_cyc - req_cyc, 6);
    if (!keep) begin
      tick();
      check_val({name, "_busy_after"}, busy, 1'b0);
      check_val({name, "_single_done"}, done_cnt, 1);
    end
    $display("burst %s addr=%08h first_aw=%0d done=%0d beats=%0d", name, addr, first_aw_cyc, done_cyc, wd_q.size());
  endtask

  logic [31:0]  a, na;
  logic [127:0] d, nd;
  bit           pend;

  initial begin
    rst           = 1'b1;
    wb_wen        = 1'b0;
    wb_waddr      = 32'd0;
    wb_wdata      = 128'd0;
    axi.awready_i = 1'b0;
    axi.wready_i  = 1'b0;
    axi.bvalid_i  = 1'b0;
    axi.bresp_i   = 2'b00;
    axi.bid_i     = '0;

    // Reset state
    repeat (3) tick();
    check_val("rst_awvalid", axi.awvalid_o, 1'b0);
    check_val("rst_wvalid", axi.wvalid_o, 1'b0);
    check_val("rst_wlast", axi.wlast_o, 1'b0);
    check_val("rst_bready", axi.bready_o, 1'b0);
    check_val("rst_done", wb_done, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_awaddr", axi.awaddr_o, 32'd0);
    check_val("rst_wdata", axi.wdata_o, 32'd0);
`ifdef WBUF_AXI_BRESP_CHECK_EN
    check_val("rst_bus_err", bus_err, 1'b0);
`endif
    rst = 1'b0;

    // Zero-wait directed burst
    run_burst("zero_wait", 32'h1FC0_0127, 128'h44444444_33333333_22222222_11111111, 1, 0, 0, 0, 1);

    // AW held off 5 cycles, beat 2 stalled 3 cycles
    aw_hold = 5; w_hold_beat = 2; w_hold = 3;
    run_burst("stall", 32'h0000_4A38, 128'h44444444_33333333_22222222_11111111, 1, 0, 0, 0, 0);
    aw_hold = 0; w_hold = 0; w_hold_beat = -1;

    // Back-to-back: request still pending at done
    run_burst("b2b_first", 32'h8000_0010, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
              1, 1, 32'h8000_0020, {4{32'hAAAA_AAAA}}, 1);
    run_burst("b2b_second", 32'h8000_0020, {4{32'hAAAA_AAAA}}, 0, 0, 0, 0, 0);

    // Reset during beat 2, then a fresh burst
    clear_mon();
    wb_wen   = 1'b1;
    wb_waddr = 32'h1234_5670;
    wb_wdata = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    for (int i = 0; i < 100 && wd_q.size() < 2; i++) tick();
    check_val("rst_mid_reach_beat2", wd_q.size(), 2);
    rst = 1'b1;
    #1;
    check_val("rst_mid_awvalid", axi.awvalid_o, 1'b0);
    check_val("rst_mid_wvalid", axi.wvalid_o, 1'b0);
    check_val("rst_mid_wlast", axi.wlast_o, 1'b0);
    check_val("rst_mid_bready", axi.bready_o, 1'b0);
    check_val("rst_mid_done", wb_done, 1'b0);
    check_val("rst_mid_busy", busy, 1'b0);
    repeat (2) tick();
    aw_stall = 0; w_stall = 0; aw_acc = 0;
    rst = 1'b0;
    run_burst("after_rst", 32'h0BAD_F00C, 128'h55555555_66666666_77777777_88888888, 1, 0, 0, 0, 1);

    // Randomised bursts with random stalls and occasional chaining
    pend = 0;
    a = $urandom;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 14; t++) begin
      bit kp;
      aw_pct = $urandom_range(100, 30);
      w_pct  = $urandom_range(100, 30);
      b_pct  = $urandom_range(100, 30);
      kp = (t < 13) && ($urandom_range(1) == 1);
      na = $urandom;
      nd = {$urandom, $urandom, $urandom, $urandom};
      run_burst($sformatf("rand%0d", t), a, d, !pend, kp, na, nd, 0);
      pend = kp;
      a = na;
      d = nd;
    end
    aw_pct = 100; w_pct = 100; b_pct = 100;

    // Error response: flow unaffected; sticky flag when enabled
`ifdef WBUF_AXI_BRESP_CHECK_EN
    check_val("bus_err_before", bus_err, 1'b0);
`endif
    bresp_val = 2'b10;
    run_burst("slverr", 32'h2000_0100, 128'h11112222_33334444_55556666_77778888, 1, 0, 0, 0, 1);
`ifdef WBUF_AXI_BRESP_CHECK_EN
    check_val("bus_err_set", bus_err, 1'b1);
`endif
    bresp_val = 2'b00;
    run_burst("okay_after_err", 32'h2000_0200, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 1, 0, 0, 0, 1);
`ifdef WBUF_AXI_BRESP_CHECK_EN
    check_val("bus_err_sticky", bus_err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
